// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, frame sizing
// and the parity helper used for the frame tail bits.
package uart_pkg;

  localparam int BAUD_W     = 20;
  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_e;

  // Even parity over the active data bits, inverted when odd sense is selected.
  function automatic logic par_bit(input logic [7:0] data, input logic eight, input logic ohel);
    logic p;
    p = eight ? (^data) : (^data[6:0]);
    return ohel ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-write and shift-register control bundle of the UART TX sequencer.
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic              write;
  logic [7:0]        tx_data;
  logic [BAUD_W-1:0] baud_k;
  logic              eight;
  logic              pen;
  logic              ohel;
  logic              txrdy;
  logic              tx_done;
  logic              ld;
  logic              sh;
  logic [6:0]        din;
  logic              bit9;
  logic              bit10;

  modport master (
    output write, tx_data, baud_k, eight, pen, ohel,
    input  txrdy, tx_done, ld, sh, din, bit9, bit10
  );

  modport slave (
    input  write, tx_data, baud_k, eight, pen, ohel,
    output txrdy, tx_done, ld, sh, din, bit9, bit10
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time divider: counts 0..k-1 while enabled and flags the terminal count.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BAUD_W-1:0] i_k,
  output logic              o_tc
);

  logic [BAUD_W-1:0] r_cnt;
  logic [BAUD_W-1:0] w_last;

  // Divisors of 0 and 1 both mean one clock per bit.
  always_comb begin
    if (i_k > BAUD_W'(1)) begin
      w_last = i_k - BAUD_W'(1);
    end else begin
      w_last = '0;
    end
    o_tc = i_en && (r_cnt >= w_last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : (r_cnt + BAUD_W'(1));
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a host byte, computes the frame tail bits
// and paces ld/sh strobes for the 11-bit TX shift register.
module uart_tx_ctrl
  import uart_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  uart_tx_ctrl_if.slave bus
);

  localparam logic [3:0] LP_FRAME = 4'(FRAME_BITS);
  localparam logic [3:0] LP_LAST  = 4'(FRAME_BITS - 1);

  tx_state_e         r_state;
  tx_state_e         w_next_state;
  logic [BAUD_W-1:0] r_baud_k;
  logic [3:0]        r_shcnt;
  logic              w_accept;
  logic              w_tc;
  logic              w_shift;

  logic              r_txrdy, r_tx_done, r_ld, r_sh, r_bit9, r_bit10;
  logic [6:0]        r_din;
  logic              w_txrdy_nxt, w_tx_done_nxt, w_ld_nxt, w_sh_nxt, w_bit9_nxt, w_bit10_nxt;
  logic [6:0]        w_din_nxt;

  // The timer runs from LOAD on, so the first terminal count lands baud_k clocks after ld.
  uart_bit_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (r_state == ST_IDLE),
    .i_en  (r_state != ST_IDLE),
    .i_k   (r_baud_k),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_accept = bus.write && r_txrdy && (r_state == ST_IDLE);
    w_shift  = (r_state != ST_IDLE) && w_tc && (r_shcnt < LP_FRAME);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // SHIFT lingers one cycle after the last sh so txrdy rises the cycle after tx_done.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  w_next_state = w_accept ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_next_state = ST_SHIFT;
      ST_SHIFT: w_next_state = (r_shcnt == LP_FRAME) ? ST_IDLE : ST_SHIFT;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ld_nxt      = w_accept;
    w_sh_nxt      = w_shift;
    w_tx_done_nxt = w_shift && (r_shcnt == LP_LAST);
    w_txrdy_nxt   = (w_next_state == ST_IDLE);
    w_din_nxt     = r_din;
    w_bit9_nxt    = r_bit9;
    w_bit10_nxt   = r_bit10;
    if (w_accept) begin
      w_din_nxt = bus.tx_data[6:0];
      case ({bus.eight, bus.pen})
        2'b00: begin
          w_bit9_nxt  = 1'b1;
          w_bit10_nxt = 1'b1;
        end
        2'b01: begin
          w_bit9_nxt  = par_bit(bus.tx_data, 1'b0, bus.ohel);
          w_bit10_nxt = 1'b1;
        end
        2'b10: begin
          w_bit9_nxt  = bus.tx_data[7];
          w_bit10_nxt = 1'b1;
        end
        2'b11: begin
          w_bit9_nxt  = bus.tx_data[7];
          w_bit10_nxt = par_bit(bus.tx_data, 1'b1, bus.ohel);
        end
        default: begin
          w_bit9_nxt  = 1'b1;
          w_bit10_nxt = 1'b1;
        end
      endcase
    end else begin
      w_din_nxt = r_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud_k <= '0;
      r_shcnt  <= 4'd0;
    end else begin
      if (w_accept) begin
        r_baud_k <= bus.baud_k;
      end else begin
        r_baud_k <= r_baud_k;
      end
      if (r_state == ST_IDLE) begin
        r_shcnt <= 4'd0;
      end else if (w_shift) begin
        r_shcnt <= r_shcnt + 4'd1;
      end else begin
        r_shcnt <= r_shcnt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_txrdy   <= 1'b1;
      r_tx_done <= 1'b0;
      r_ld      <= 1'b0;
      r_sh      <= 1'b0;
      r_din     <= 7'h7F;
      r_bit9    <= 1'b1;
      r_bit10   <= 1'b1;
    end else begin
      r_txrdy   <= w_txrdy_nxt;
      r_tx_done <= w_tx_done_nxt;
      r_ld      <= w_ld_nxt;
      r_sh      <= w_sh_nxt;
      r_din     <= w_din_nxt;
      r_bit9    <= w_bit9_nxt;
      r_bit10   <= w_bit10_nxt;
    end
  end

  assign bus.txrdy   = r_txrdy;
  assign bus.tx_done = r_tx_done;
  assign bus.ld      = r_ld;
  assign bus.sh      = r_sh;
  assign bus.din     = r_din;
  assign bus.bit9    = r_bit9;
  assign bus.bit10   = r_bit10;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: table of frames with hand-computed tail bits
// and strobe timing, plus busy-write, divisor-change and mid-frame reset sequences.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_ctrl_if u_if ();
  uart_tx_ctrl dut (.clk(clk), .reset(reset), .bus(u_if));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ld_q[$];
  int sh_q[$];
  int done_q[$];
  logic [6:0] cap_din;
  logic cap_b9, cap_b10;

  always @(negedge clk) begin
    if (u_if.ld === 1'b1) begin
      ld_q.push_back(cyc);
      cap_din = u_if.din;
      cap_b9  = u_if.bit9;
      cap_b10 = u_if.bit10;
    end
    if (u_if.sh === 1'b1) sh_q.push_back(cyc);
    if (u_if.tx_done === 1'b1) done_q.push_back(cyc);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    ld_q.delete();
    sh_q.delete();
    done_q.delete();
  endtask

  task automatic go_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                             input int k, output int n0);
    u_if.tx_data = d;
    u_if.eight   = e;
    u_if.pen     = p;
    u_if.ohel    = o;
    u_if.baud_k  = BAUD_W'(k);
    u_if.write   = 1'b1;
    n0 = cyc;
    clear_q();
    @(negedge clk);
    u_if.write = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input int n0, input int k,
                              input logic [6:0] edin, input logic eb9, input logic eb10);
    int t;
    int ke;
    int first;
    int last;
    int gaps;
    t = 0;
    while (u_if.txrdy !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ke = (k < 2) ? 1 : k;
    chk({tag, "_timeout"}, (t < 2000), 1);
    chk({tag, "_txrdy_cyc"}, cyc, n0 + 2 + 11 * ke);
    chk({tag, "_ld_cnt"}, ld_q.size(), 1);
    chk({tag, "_ld_cyc"}, (ld_q.size() > 0) ? ld_q[0] : -1, n0 + 1);
    chk({tag, "_sh_cnt"}, sh_q.size(), 11);
    first = (sh_q.size() > 0) ? sh_q[0] : -1;
    last  = (sh_q.size() > 0) ? sh_q[sh_q.size() - 1] : -1;
    chk({tag, "_sh_first"}, first, n0 + 1 + ke);
    chk({tag, "_sh_last"}, last, n0 + 1 + 11 * ke);
    gaps = 0;
    for (int i = 1; i < sh_q.size(); i++) if (sh_q[i] - sh_q[i-1] != ke) gaps++;
    chk({tag, "_sh_gaps"}, gaps, 0);
    chk({tag, "_done_cnt"}, done_q.size(), 1);
    chk({tag, "_done_cyc"}, (done_q.size() > 0) ? done_q[0] : -1, n0 + 1 + 11 * ke);
    chk({tag, "_din"}, cap_din, edin);
    chk({tag, "_bit9"}, cap_b9, eb9);
    chk({tag, "_bit10"}, cap_b10, eb10);
    chk({tag, "_din_hold"}, u_if.din, edin);
    chk({tag, "_b10_hold"}, u_if.bit10, eb10);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       e;
    logic       p;
    logic       o;
    int         k;
    logic [6:0] din;
    logic       b9;
    logic       b10;
  } vec_t;

  vec_t vecs[9];

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txrdy"}, u_if.txrdy, 1);
    chk({tag, "_ld"}, u_if.ld, 0);
    chk({tag, "_sh"}, u_if.sh, 0);
    chk({tag, "_done"}, u_if.tx_done, 0);
    chk({tag, "_din"}, u_if.din, 7'h7F);
    chk({tag, "_bit9"}, u_if.bit9, 1);
    chk({tag, "_bit10"}, u_if.bit10, 1);
  endtask

  initial begin
    int n0;
    int n1;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 4, 7'h25, 1'b1, 1'b0};
    vecs[1] = '{8'h03, 1'b0, 1'b1, 1'b1, 2, 7'h03, 1'b1, 1'b1};
    vecs[2] = '{8'h03, 1'b0, 1'b0, 1'b1, 3, 7'h03, 1'b1, 1'b1};
    vecs[3] = '{8'h03, 1'b0, 1'b1, 1'b0, 1, 7'h03, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b0, 0, 7'h5A, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 2, 7'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1, 7'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h86, 1'b0, 1'b1, 1'b0, 1, 7'h06, 1'b0, 1'b1};
    vecs[8] = '{8'hC1, 1'b0, 1'b1, 1'b1, 2, 7'h41, 1'b1, 1'b1};

    reset        = 1'b0;
    u_if.write   = 1'b0;
    u_if.tx_data = 8'h00;
    u_if.baud_k  = BAUD_W'(4);
    u_if.eight   = 1'b0;
    u_if.pen     = 1'b0;
    u_if.ohel    = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst_held");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_rel");

    for (int i = 0; i < 9; i++) begin
      start_frame(vecs[i].data, vecs[i].e, vecs[i].p, vecs[i].o, vecs[i].k, n0);
      finish_frame($sformatf("vec%0d", i), n0, vecs[i].k, vecs[i].din, vecs[i].b9, vecs[i].b10);
      @(negedge clk);
    end

    // Writes while busy and on the tx_done cycle are dropped; first txrdy cycle is accepted.
    start_frame(8'hA5, 1'b1, 1'b1, 1'b0, 2, n0);
    go_to(n0 + 10);
    u_if.write   = 1'b1;
    u_if.tx_data = 8'h00;
    @(negedge clk);
    u_if.write = 1'b0;
    go_to(n0 + 23);
    chk("busy_done_now", u_if.tx_done, 1);
    u_if.write = 1'b1;
    go_to(n0 + 24);
    chk("busy_txrdy", u_if.txrdy, 1);
    chk("busy_ld_cnt", ld_q.size(), 1);
    chk("busy_sh_cnt", sh_q.size(), 11);
    chk("busy_done_cyc", (done_q.size() > 0) ? done_q[0] : -1, n0 + 23);
    chk("busy_din_hold", u_if.din, 7'h25);
    clear_q();
    u_if.tx_data = 8'h3C;
    n1 = cyc;
    @(negedge clk);
    u_if.write = 1'b0;
    finish_frame("acc", n1, 2, 7'h3C, 1'b0, 1'b0);
    @(negedge clk);

    // Divisor change after acceptance must not alter pacing.
    start_frame(8'h55, 1'b1, 1'b0, 1'b0, 3, n0);
    go_to(n0 + 3);
    u_if.baud_k = BAUD_W'(7);
    finish_frame("bchg", n0, 3, 7'h55, 1'b0, 1'b1);
    @(negedge clk);

    // Reset right after the fifth shift, then a clean full frame.
    start_frame(8'h0F, 1'b1, 1'b1, 1'b0, 2, n0);
    go_to(n0 + 10);
    chk("mrst_sh_before", sh_q.size(), 4);
    go_to(n0 + 11);
    chk("mrst_sh5", u_if.sh, 1);
    reset = 1'b0;
    #1;
    chk_reset_vals("mrst_now");
    clear_q();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("mrst_no_sh", sh_q.size(), 0);
    chk("mrst_no_ld", ld_q.size(), 0);
    chk("mrst_txrdy", u_if.txrdy, 1);
    start_frame(8'h0F, 1'b1, 1'b1, 1'b0, 2, n0);
    finish_frame("post_rst", n0, 2, 7'h0F, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
